video_sig_gen: RTL and testbench

// - Raster timing generator on the pixel clock; the stage directly upstream of the per-channel TMDS encoders.
// - Emits pixel/line counts, hsync, vsync, active-draw and new-frame strobes; default 1280x720@60 (74.25 MHz).
// - hs_out/vs_out feed the blue encoder control_in as {vs,hs}; ad_out drives encoder ve_in for all three channels.

---
 rtl/video_timing_pkg.sv | 41 ++++
 rtl/wrap_counter.sv | 36 +++
 rtl/video_sig_gen.sv | 124 ++++++++++++
 tb/tb_video_sig_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
//------------------------------------------------------------------------------
// Module  : video_timing_pkg
// Brief   : Shared raster timing constants (720p60 defaults) and mode struct.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package video_timing_pkg;

  localparam int c_h_active = 1280;
  localparam int c_h_fp     = 110;
  localparam int c_h_sync   = 40;
  localparam int c_h_bp     = 220;
  localparam int c_v_active = 720;
  localparam int c_v_fp     = 5;
  localparam int c_v_sync   = 5;
  localparam int c_v_bp     = 20;
  localparam int c_fps      = 60;

  localparam int c_total_pixels = c_h_active + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_total_lines  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } video_timing_t;

  localparam video_timing_t c_mode_720p60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20
  };

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
//------------------------------------------------------------------------------
// Module  : wrap_counter
// Brief   : Enabled modulo-MAX counter with a combinational wrap strobe.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wrap_counter #(
  parameter int MAX = 1650
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en_in,
  output logic [$clog2(MAX)-1:0] count_out,
  output logic                   wrap_out
);

  localparam int                  c_w    = $clog2(MAX);
  localparam logic [c_w-1:0]      c_last = c_w'(MAX - 1);

  logic [c_w-1:0] r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (en_in) begin
      r_count <= (r_count == c_last) ? '0 : r_count + c_w'(1);
    end
  end

  assign count_out = r_count;
  assign wrap_out  = en_in && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/video_sig_gen.sv
//------------------------------------------------------------------------------
// Module  : video_sig_gen
// Brief   : Raster timing generator (counts, hsync, vsync, active, new-frame).
//           Frame counter enabled by defining VIDEO_SIG_GEN_FRAME_COUNT_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = c_h_active,
  parameter int H_FRONT_PORCH   = c_h_fp,
  parameter int H_SYNC_WIDTH    = c_h_sync,
  parameter int H_BACK_PORCH    = c_h_bp,
  parameter int ACTIVE_LINES    = c_v_active,
  parameter int V_FRONT_PORCH   = c_v_fp,
  parameter int V_SYNC_WIDTH    = c_v_sync,
  parameter int V_BACK_PORCH    = c_v_bp,
  parameter int FPS             = c_fps
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic [$clog2(ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH+H_BACK_PORCH)-1:0] hcount_out,
  output logic [$clog2(ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH+V_BACK_PORCH)-1:0]    vcount_out,
  output logic hs_out,
  output logic vs_out,
  output logic ad_out,
  output logic nf_out,
  output logic [$clog2(FPS)-1:0] fc_out
);

  localparam int c_total_h = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int c_total_v = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int c_hw  = $clog2(c_total_h);
  localparam int c_vw  = $clog2(c_total_v);
  localparam int c_hxw = c_hw + 1;
  localparam int c_vxw = c_vw + 1;

  // One spare bit so a sync end equal to the total (zero back porch) stays representable.
  localparam logic [c_hxw-1:0] c_h_act  = c_hxw'(ACTIVE_H_PIXELS);
  localparam logic [c_hxw-1:0] c_hs_beg = c_hxw'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [c_hxw-1:0] c_hs_end = c_hxw'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [c_vxw-1:0] c_v_act  = c_vxw'(ACTIVE_LINES);
  localparam logic [c_vxw-1:0] c_vs_beg = c_vxw'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [c_vxw-1:0] c_vs_end = c_vxw'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  logic [c_hw-1:0]  w_h;
  logic [c_vw-1:0]  w_v;
  logic [c_hxw-1:0] w_hx;
  logic [c_vxw-1:0] w_vx;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_unused;
  logic             w_ad;
  logic             w_hs;
  logic             w_vs;
  logic             w_nf;

  // Counters hold the pixel to be presented on the next edge; outputs lag them by one.
  wrap_counter #(.MAX(c_total_h)) u_hcnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (1'b1),
    .count_out (w_h),
    .wrap_out  (w_h_wrap)
  );

  wrap_counter #(.MAX(c_total_v)) u_vcnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (w_h_wrap),
    .count_out (w_v),
    .wrap_out  (w_v_wrap)
  );

  assign w_unused = w_v_wrap;
  assign w_hx = {1'b0, w_h};
  assign w_vx = {1'b0, w_v};
  assign w_ad = (w_hx < c_h_act) && (w_vx < c_v_act);
  assign w_hs = (w_hx >= c_hs_beg) && (w_hx < c_hs_end);
  assign w_vs = (w_vx >= c_vs_beg) && (w_vx < c_vs_end);
  assign w_nf = (w_hx == c_h_act) && (w_vx == c_v_act);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
    end else begin
      hcount_out <= w_h;
      vcount_out <= w_v;
      hs_out     <= w_hs;
      vs_out     <= w_vs;
      ad_out     <= w_ad;
      nf_out     <= w_nf;
    end
  end

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
  localparam int               c_fw      = $clog2(FPS);
  localparam logic [c_fw-1:0]  c_fc_last = c_fw'(FPS - 1);

  logic [c_fw-1:0] r_fc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fc <= '0;
    end else if (w_nf) begin
      r_fc <= (r_fc == c_fc_last) ? '0 : r_fc + c_fw'(1);
    end
  end

  assign fc_out = r_fc;
`else
  assign fc_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_sig_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_video_sig_gen
// Brief   : Self-checking bench for video_sig_gen on a reduced 32x16 raster.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_sig_gen;

  localparam int AH = 20, HFP = 3, HSW = 4, HBP = 5;
  localparam int AV = 10, VFP = 3, VSW = 3, VBP = 0;
  localparam int NFPS = 60;
  localparam int TP = AH + HFP + HSW + HBP;   // 32
  localparam int TL = AV + VFP + VSW + VBP;   // 16
  localparam int FRAME = TP * TL;             // 512
  localparam int NF_OFF = AV * TP + AH;       // 340

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hcount;
  logic [3:0] vcount;
  logic       hs, vs, ad, nf;
  logic [5:0] fc;

  int checks = 0;
  int errors = 0;

  // model state: m_n is the index of the pixel currently presented since reset release
  int m_n     = -1;
  bit m_valid = 1'b0;
  bit m_rst   = 1'b0;

  video_sig_gen #(
    .ACTIVE_H_PIXELS (AH), .H_FRONT_PORCH (HFP), .H_SYNC_WIDTH (HSW), .H_BACK_PORCH (HBP),
    .ACTIVE_LINES    (AV), .V_FRONT_PORCH (VFP), .V_SYNC_WIDTH (VSW), .V_BACK_PORCH (VBP),
    .FPS             (NFPS)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .hcount_out (hcount),
    .vcount_out (vcount),
    .hs_out     (hs),
    .vs_out     (vs),
    .ad_out     (ad),
    .nf_out     (nf),
    .fc_out     (fc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_rst   = 1'b1;
      m_n     = -1;
    end else if (m_valid) begin
      m_rst = 1'b0;
      m_n   = m_n + 1;
    end
  end

  int e_h, e_v, e_ad, e_hs, e_vs, e_nf, e_fc, e_frames;

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_rst) begin
        e_h = 0; e_v = 0; e_ad = 0; e_hs = 0; e_vs = 0; e_nf = 0; e_fc = 0;
      end else begin
        e_h  = m_n % TP;
        e_v  = (m_n / TP) % TL;
        e_ad = int'((e_h < AH) && (e_v < AV));
        e_hs = int'((e_h >= AH + HFP) && (e_h < AH + HFP + HSW));
        e_vs = int'((e_v >= AV + VFP) && (e_v < AV + VFP + VSW));
        e_nf = int'((e_h == AH) && (e_v == AV));
        e_frames = (m_n >= NF_OFF) ? ((m_n - NF_OFF) / FRAME + 1) : 0;
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        e_fc = e_frames % NFPS;
`else
        e_fc = 0;
`endif
      end
      checks++;
      if (int'(hcount) != e_h || int'(vcount) != e_v || int'(ad) != e_ad || int'(hs) != e_hs ||
          int'(vs) != e_vs || int'(nf) != e_nf || int'(fc) != e_fc) begin
        errors++;
        $display("FAIL cycle_cmp n=%0d act h=%0d v=%0d ad=%0d hs=%0d vs=%0d nf=%0d fc=%0d exp h=%0d v=%0d ad=%0d hs=%0d vs=%0d nf=%0d fc=%0d",
                 m_n, hcount, vcount, ad, hs, vs, nf, fc, e_h, e_v, e_ad, e_hs, e_vs, e_nf, e_fc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_pix(input string name, input int h, input int v, input int a,
                         input int hsx, input int vsx, input int nfx);
    chk({name, ".h"}, int'(hcount), h);
    chk({name, ".v"}, int'(vcount), v);
    chk({name, ".ad"}, int'(ad), a);
    chk({name, ".hs"}, int'(hs), hsx);
    chk({name, ".vs"}, int'(vs), vsx);
    chk({name, ".nf"}, int'(nf), nfx);
  endtask

  // Advance to the negedge at which the model presents pixel index target.
  task automatic wait_n(input int target);
    int budget;
    budget = target - m_n + 4;
    while (!(m_rst == 1'b0 && m_n == target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (!(m_rst == 1'b0 && m_n == target)) begin
      errors++;
      $display("FAIL wait_n act=%0d exp=%0d", m_n, target);
    end
  endtask

  int fc_on;

  initial begin
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    fc_on = 1;
`else
    fc_on = 0;
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_pix("held_reset", 0, 0, 0, 0, 0, 0);
    chk("held_reset.fc", int'(fc), 0);

    rst = 1'b0;
    @(negedge clk);
    wait_n(0);
    chk_pix("first_pixel", 0, 0, 1, 0, 0, 0);
    chk("first_pixel.fc", int'(fc), 0);
    wait_n(19);  chk_pix("last_active_px", 19, 0, 1, 0, 0, 0);
    wait_n(20);  chk_pix("first_blank_px", 20, 0, 0, 0, 0, 0);
    wait_n(22);  chk_pix("pre_hsync", 22, 0, 0, 0, 0, 0);
    wait_n(23);  chk_pix("hsync_rise", 23, 0, 0, 1, 0, 0);
    wait_n(26);  chk_pix("hsync_last", 26, 0, 0, 1, 0, 0);
    wait_n(27);  chk_pix("hsync_fall", 27, 0, 0, 0, 0, 0);
    wait_n(31);  chk_pix("line_end", 31, 0, 0, 0, 0, 0);
    wait_n(32);  chk_pix("line_wrap", 0, 1, 1, 0, 0, 0);
    wait_n(340); chk_pix("new_frame", 20, 10, 0, 0, 0, 1);
    chk("new_frame.fc", int'(fc), fc_on);
    wait_n(407); chk_pix("vblank_hsync", 23, 12, 0, 1, 0, 0);
    wait_n(415); chk_pix("pre_vsync", 31, 12, 0, 0, 0, 0);
    wait_n(416); chk_pix("vsync_rise", 0, 13, 0, 0, 1, 0);
    wait_n(511); chk_pix("frame_end", 31, 15, 0, 0, 1, 0);
    wait_n(512); chk_pix("frame_wrap", 0, 0, 1, 0, 0, 0);
    chk("frame_wrap.fc", int'(fc), fc_on);
    wait_n(NF_OFF + 59 * FRAME - 1);
    chk("fc_before_wrap", int'(fc), fc_on * 59);
    wait_n(NF_OFF + 59 * FRAME);
    chk("fc_wrap", int'(fc), 0);
    chk("fc_wrap.nf", int'(nf), 1);

    // mid-frame reset at pixel (5,7)
    wait_n(60 * FRAME + 7 * TP + 5);
    chk_pix("pre_mid_reset", 5, 7, 1, 0, 0, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_pix("mid_reset", 0, 0, 0, 0, 0, 0);
      chk("mid_reset.fc", int'(fc), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_pix("after_reset", 0, 0, 1, 0, 0, 0);
    chk("after_reset.fc", int'(fc), 0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 1200)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (600) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
